// File: rtl/alu_seq_param.sv
// Handshaked WIDTH-generic ALU: 1-cycle ops, WIDTH+1-cycle shift-add MUL, one op in flight.
// in_ready only in IDLE; Result/flags held in DONE until out_ready (one bubble per op).
module alu_seq_param #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic [SHW-1:0]   shamt,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             IllegalOp
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;

  logic [WIDTH:0]     add_sum, sub_sum;
  logic               add_ovf, sub_ovf;
  logic [WIDTH-1:0]   c_res;
  logic               c_ovf, c_cy, c_ill;

  logic [2*WIDTH-1:0] acc, mcand, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  // SUB is A + ~B + 1 so CarryOut means "no borrow"
  always_comb begin
    add_sum = {1'b0, A} + {1'b0, B};
    sub_sum = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf = (A[WIDTH-1] == B[WIDTH-1])  & (add_sum[WIDTH-1] != A[WIDTH-1]);
    sub_ovf = (A[WIDTH-1] == ~B[WIDTH-1]) & (sub_sum[WIDTH-1] != A[WIDTH-1]);
    c_res = '0;
    c_ovf = 1'b0;
    c_cy  = 1'b0;
    c_ill = 1'b0;
    case (ALUOp)
      OP_AND:  c_res = A & B;
      OP_OR:   c_res = A | B;
      OP_ADD:  begin c_res = add_sum[WIDTH-1:0]; c_ovf = add_ovf; c_cy = add_sum[WIDTH]; end
      OP_XOR:  c_res = A ^ B;
      OP_NOR:  c_res = ~(A | B);
      OP_SUB:  begin c_res = sub_sum[WIDTH-1:0]; c_ovf = sub_ovf; c_cy = sub_sum[WIDTH]; end
      // sign of the true difference, robust against overflow of the raw MSB
      OP_SLT:  c_res = {{(WIDTH-1){1'b0}}, sub_sum[WIDTH-1] ^ sub_ovf};
      OP_SLTU: c_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  c_res = A << shamt;
      OP_SRL:  c_res = A >> shamt;
      OP_SRA:  c_res = WIDTH'($signed(A) >>> shamt);
      OP_MUL:  c_res = '0;
      default: c_ill = 1'b1;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b1;
      Overflow  <= 1'b0;
      CarryOut  <= 1'b0;
      IllegalOp <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (ALUOp == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
            cnt    <= '0;
            state  <= MUL;
          end else begin
            Result    <= c_res;
            Zero      <= (c_res == '0);
            Overflow  <= c_ovf;
            CarryOut  <= c_cy;
            IllegalOp <= c_ill;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        // one multiplier bit per cycle, LSB first; always WIDTH iterations
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) begin
            Result    <= acc_next[WIDTH-1:0];
            Zero      <= (acc_next[WIDTH-1:0] == '0);
            Overflow  <= |acc_next[2*WIDTH-1:WIDTH];
            CarryOut  <= 1'b0;
            IllegalOp <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=16) with an expected-result queue.
module tb_alu_seq_param;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [W-1:0]  A, B;
  logic [3:0]    ALUOp;
  logic [SW-1:0] shamt;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  Result;
  logic          Zero, Overflow, CarryOut, IllegalOp;

  typedef struct {
    logic [W-1:0] res;
    logic         z, ov, cy, ill;
  } exp_t;
  exp_t sb[$];

  int tests_run = 0;
  int fails     = 0;

  alu_seq_param #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .ALUOp(ALUOp), .shamt(shamt),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one op, wait for its result, compare against the queued expectation,
  // optionally hold out_ready low for `hold` cycles while checking stability.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] sh,
                        input logic [W-1:0] er, input logic ez, input logic eov,
                        input logic ecy, input logic eill, input int elat, input int hold);
    exp_t e;
    int   lat;
    @(negedge Clock);
    out_ready = (hold == 0);
    A = a; B = b; ALUOp = op; shamt = sh; in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    e.res = er; e.z = ez; e.ov = eov; e.cy = ecy; e.ill = eill;
    sb.push_back(e);
    @(negedge Clock);
    in_valid = 1'b0; A = ~a; B = ~b; ALUOp = 4'hF;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge Clock);
      A = W'($urandom); B = W'($urandom);
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, ".Result"},    Result,    e.res);
      check({tag, ".Zero"},      Zero,      e.z);
      check({tag, ".Overflow"},  Overflow,  e.ov);
      check({tag, ".CarryOut"},  CarryOut,  e.cy);
      check({tag, ".IllegalOp"}, IllegalOp, e.ill);
      for (int i = 0; i < hold; i++) begin
        @(negedge Clock);
        A = W'($urandom);
        check({tag, ".hold_valid"},  out_valid, 1);
        check({tag, ".hold_ready"},  in_ready,  0);
        check({tag, ".hold_Result"}, Result,    e.res);
        check({tag, ".hold_flags"},  {Zero, Overflow, CarryOut, IllegalOp},
              {e.z, e.ov, e.cy, e.ill});
      end
    end
    out_ready = 1'b1;
    @(negedge Clock);
    check({tag, ".drain_valid"}, out_valid, 0);
    check({tag, ".drain_ready"}, in_ready,  1);
  endtask

  initial begin
    logic [W-1:0]   ra, rb, rexp;
    logic [2*W-1:0] prod;
    logic [3:0]     lop;
    int             lat;

    Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; ALUOp = '0; shamt = '0;
    repeat (2) @(negedge Clock);
    check("reset.in_ready",  in_ready,  1);
    check("reset.out_valid", out_valid, 0);
    check("reset.Result",    Result,    0);
    check("reset.flags",     {Zero, Overflow, CarryOut, IllegalOp}, 4'b1000);
    Reset = 1'b0;

    run_op("add_ovf", 4'b0010, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0, 0, 1, 0);
    run_op("sub_eq",  4'b0110, 16'h0005, 16'h0005, 0, 16'h0000, 1, 0, 1, 0, 1, 0);
    run_op("slt",     4'b0111, 16'h8000, 16'h0001, 0, 16'h0001, 0, 0, 0, 0, 1, 0);
    run_op("sltu",    4'b1000, 16'h8000, 16'h0001, 0, 16'h0000, 1, 0, 0, 0, 1, 0);
    run_op("sra",     4'b1011, 16'h8000, 16'h0000, 3, 16'hF000, 0, 0, 0, 0, 1, 0);
    run_op("srl",     4'b1010, 16'h8000, 16'h0000, 3, 16'h1000, 0, 0, 0, 0, 1, 0);
    run_op("sll",     4'b1001, 16'h0001, 16'h0000, 15, 16'h8000, 0, 0, 0, 0, 1, 0);
    run_op("sll0",    4'b1001, 16'h1234, 16'h0000, 0, 16'h1234, 0, 0, 0, 0, 1, 0);
    run_op("sub_brw", 4'b0110, 16'h0001, 16'h0002, 0, 16'hFFFF, 0, 0, 0, 0, 1, 0);
    run_op("mul_ovf", 4'b1100, 16'h0100, 16'h0100, 0, 16'h0000, 1, 1, 0, 0, 17, 0);
    run_op("mul_bp",  4'b1100, 16'h00FF, 16'h0003, 0, 16'h02FD, 0, 0, 0, 0, 17, 5);
    run_op("add_bp",  4'b0010, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, 0, 1, 3);

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      case (i)
        0: begin lop = 4'b0000; rexp = ra & rb;    end
        1: begin lop = 4'b0001; rexp = ra | rb;    end
        2: begin lop = 4'b0011; rexp = ra ^ rb;    end
        default: begin lop = 4'b0100; rexp = ~(ra | rb); end
      endcase
      run_op("logic_rand", lop, ra, rb, 0, rexp, (rexp == '0), 0, 0, 0, 1, 0);
    end

    for (int i = 0; i < 2; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      prod = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
      run_op("mul_rand", 4'b1100, ra, rb, 0, prod[W-1:0], (prod[W-1:0] == '0),
             |prod[2*W-1:W], 0, 0, 17, 0);
    end

    // Reset during cycle 8 of a multiply
    @(negedge Clock);
    A = 16'h1234; B = 16'h5678; ALUOp = 4'b1100; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    lat = 1;
    while (lat < 8) begin
      @(negedge Clock);
      lat++;
    end
    check("mul_busy.in_ready", in_ready, 0);
    Reset = 1'b1; in_valid = 1'b1;
    @(negedge Clock);
    check("rst_mid.in_ready",  in_ready,  1);
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.Result",    Result,    0);
    check("rst_mid.flags",     {Zero, Overflow, CarryOut, IllegalOp}, 4'b1000);
    @(negedge Clock);
    check("rst_hold.in_ready", in_ready, 1);
    Reset = 1'b0; in_valid = 1'b0;

    run_op("illegal", 4'b1111, 16'hABCD, 16'h1111, 0, 16'h0000, 1, 0, 0, 1, 1, 0);
    run_op("after_ill", 4'b0010, 16'h0001, 16'h0001, 0, 16'h0002, 0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
